// File: rtl/fp_pkg.sv
// Shared FPU definitions: operand width, add/sub opcodes, unit latency.
// Imported by the FPU arbiters and by the FP add/sub unit wrapper.
package fp_pkg;

    localparam int FP_W = 32;

    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_SUB = 1'b1;

    localparam int FP_ADDSUB_LATENCY = 3;

    // Operand bundle captured by an issue stage
    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            op;
    } fp_operands_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grant the first set req at or after ptr.
// Ports: req (N), ptr (start index), en (gate), gnt (one-hot or zero).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] back;

    // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
    assign dbl     = {req, req} >> ptr;
    assign rot     = dbl[N-1:0];
    assign rot_gnt = rot & (~rot + 1'b1);
    assign back    = {rot_gnt, rot_gnt} << ptr;
    assign gnt     = en ? back[2*N-1:N] : '0;

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one pipelined FP add/sub unit among NUM_REQ requesters.
// Ports: clk, areset_n (sync, active-low), enable, req_* (per-requester
// request bundle), fp_a/fp_b/fp_opsel (to unit), fp_q (from unit),
// resp_valid/resp_id/resp_q (result), in_flight, idle.
module fp_addsub_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int LATENCY = FP_ADDSUB_LATENCY,
    parameter int CNT_W   = $clog2(LATENCY + 2)
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_opsel,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [FP_W-1:0]         fp_a,
    output logic [FP_W-1:0]         fp_b,
    output logic                    fp_opsel,
    input  logic [FP_W-1:0]         fp_q,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [FP_W-1:0]         resp_q,
    output logic [CNT_W-1:0]        in_flight,
    output logic                    idle
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [ID_W-1:0]    acc_id;
    fp_operands_t       sel_ops;

    fp_operands_t       iss;
    logic               iss_valid;
    logic [ID_W-1:0]    iss_id;

    logic               tag_v  [LATENCY];
    logic [ID_W-1:0]    tag_id [LATENCY];

    // Grants are suppressed while reset is held
    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (enable & areset_n),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        acc_id  = '0;
        sel_ops = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                acc_id     = ID_W'(i);
                sel_ops.a  = req_a[i*FP_W +: FP_W];
                sel_ops.b  = req_b[i*FP_W +: FP_W];
                sel_ops.op = req_opsel[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            rr_ptr    <= '0;
            iss       <= '0;
            iss_valid <= 1'b0;
            iss_id    <= '0;
            in_flight <= '0;
            for (int j = 0; j < LATENCY; j++) begin
                tag_v[j]  <= 1'b0;
                tag_id[j] <= '0;
            end
        end else begin
            iss_valid <= accept;
            if (accept) begin
                iss    <= sel_ops;
                iss_id <= acc_id;
                rr_ptr <= (acc_id == ID_W'(NUM_REQ - 1)) ? '0 : acc_id + 1'b1;
            end

            // Ownership tags shift in lock-step with the unit pipeline
            tag_v[LATENCY-1]  <= iss_valid;
            tag_id[LATENCY-1] <= iss_id;
            for (int j = 0; j < LATENCY - 1; j++) begin
                tag_v[j]  <= tag_v[j+1];
                tag_id[j] <= tag_id[j+1];
            end

            unique case ({accept, resp_valid})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: ;
            endcase
        end
    end

    assign fp_a       = iss.a;
    assign fp_b       = iss.b;
    assign fp_opsel   = iss.op;

    assign resp_valid = tag_v[0];
    assign resp_id    = tag_id[0];
    assign resp_q     = fp_q;

    assign idle       = (in_flight == '0);

endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
Shares one fully pipelined FP add/sub unit among NUM_REQ requesters: for example, the per-lane FPU clients in a core.
- Arbitrates round-robin and issues at most one operation per cycle into the unit through a registered issue stage.
- Tracks requester ownership of every in-flight operation in a tag pipeline matched to the unit latency.
- Returns each result with its requester ID.
- The unit has fixed latency and no stall, so the arbiter needs no response backpressure.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
ID_W, $clog2(NUM_REQ), requester ID width
LATENCY, 3, FP unit latency in cycles from operand capture to q valid; must match the instantiated unit
CNT_W, $clog2(LATENCY+2), width of in-flight counter

Ports:
clk  in  1  clock
areset_n  in  1  reset, synchronous, active-low
enable  in  1  when 0, no new grants; in-flight ops still complete
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero)
req_opsel  in  NUM_REQ  0 = add, 1 = sub (bit i for requester i)
req_a  in  32*NUM_REQ  operand A, slice i for requester i
req_b  in  32*NUM_REQ  operand B
fp_a  out  32  registered operand A to unit
fp_b  out  32  registered operand B to unit
fp_opsel  out  1  registered opSel to unit
fp_q  in  32  unit result
resp_valid  out  1  result valid this cycle
resp_id  out  ID_W  owning requester of resp_q
resp_q  out  32  result (= fp_q)
in_flight  out  CNT_W  operations issued but not yet returned
idle  out  1  in_flight == 0 and issue stage empty

Behaviour:
Reset (areset_n = 0 at a clk edge):
- rr_ptr = 0; issue stage cleared (fp_a = fp_b = 0, fp_opsel = 0, issue_valid = 0).
- All tag-pipeline valids = 0, so resp_valid = 0 and resp_id = 0.
- in_flight = 0 and idle = 1.
- The unit's internal results are not cleared. Tag valids gate them, so no stale resp_valid appears after reset, including reset mid-operation.

Arbitration:
- Combinational round-robin. Search starts at index rr_ptr and wraps modulo NUM_REQ.
- The first i with req_valid[i] = 1 gets req_ready[i] = 1, provided enable = 1 and the block is not in reset.
- Handshake: a request is accepted on an edge where req_valid[i] and req_ready[i] are both 1.
- On accept, rr_ptr <= (i+1) mod NUM_REQ. With no accept, rr_ptr holds.
- req_valid may drop without acceptance; no stickiness is required.

Issue stage:
- On the accept edge k: fp_a <= req_a slice i, fp_b <= req_b slice i, fp_opsel <= req_opsel[i], issue_valid <= 1, issue_id <= i.
- With no accept: issue_valid <= 0 and operands hold their previous values.

Tag pipeline:
- Depth LATENCY, shifting every cycle unconditionally.
- Stage LATENCY-1 loads {issue_valid, issue_id}; stage j loads stage j+1; stage 0 drives resp_valid and resp_id.
- resp_q = fp_q combinationally.

Latency:
- A request accepted at edge k appears with resp_valid = 1 in the cycle after edge k+LATENCY. This is LATENCY+1 cycles after the request cycle, 4 by default.
- Throughput is 1 op/cycle. Results return in issue order.

in_flight:
- Increments on accept and decrements when resp_valid = 1; both in the same cycle leaves it unchanged.
- Maximum value is LATENCY+1.
- idle = (in_flight == 0).

enable:
- Deasserting enable blocks grants from the same cycle and never cancels issued ops.
- Re-enabling resumes arbitration from the held rr_ptr.

Decomposition:
Shared package fp_pkg:
- FP_W = 32.
- Opcode constants FP_OP_ADD = 1'b0 and FP_OP_SUB = 1'b1.
- FP_ADDSUB_LATENCY = 3, used by both this block and the unit wrapper.

Sub-module rr_arbiter (params N):
- Inputs: req, ptr, en. Output: one-hot grant.
- Pure combinational priority rotate; reusable by the other FPU arbiters (mul, div).

The tag pipeline and counter stay in fp_addsub_arbiter. The FP unit itself is instantiated by the parent, not inside this block.

Test Plan:
- Single add: requester 2 sends a = 0x3F800000, b = 0x40000000, opsel = 0 at cycle 0 → req_ready = 0b0100 at cycle 0; resp_valid = 1 at cycle 4 with resp_id = 2 and resp_q = 0x40400000; in_flight goes 1→0 after cycle 4.
- Subtract: requester 0 sends 0x40A00000 − 0x40400000 (opsel = 1) → resp_q = 0x40000000 and resp_id = 0, four cycles later.
- All four request continuously from cycle 0 → grants 0,1,2,3,0 on cycles 0–4; resp_valid is high on cycles 4–8 with IDs 0,1,2,3,0; in_flight saturates at 4 (LATENCY+1).
- Fairness: requesters 1 and 3 held valid for 8 cycles with rr_ptr = 0 → grants alternate 1,3,1,3,…, with neither starved.
- enable dropped at cycle 2 during a continuous burst → req_ready = 0 from cycle 2; two responses (cycles 4, 5), then idle = 1 from cycle 6; re-enable resumes at rr_ptr = 2.
- Reset mid-op: three ops accepted on cycles 0–2, areset_n = 0 for cycle 3 → resp_valid = 0 for all following cycles, in_flight = 0, idle = 1; a new request at cycle 5 returns correctly at cycle 9.
